// File: rtl/call_stack_ctrl.sv
// Return-address stack (circular buffer). Optional overflow/underflow trap via CALL_STACK_FAULT_EN.
// Latency: pop 0 cycles (top is combinational from registered state), push visible 1 cycle later.
// Backpressure: none; a trapped fault freezes the PC through halt until clear_fault.
module call_stack_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              ret_addr_in,
    input  logic                       clear_fault,
    output logic [AW-1:0]              ret_addr_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       halt,
    output logic [1:0]                 fault_code
);

    localparam int TW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [TW-1:0] top_q, top_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en;
    logic [TW-1:0] wr_idx;
    logic          is_empty, is_full;
    logic          run_ok;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);

`ifdef CALL_STACK_FAULT_EN
    typedef enum logic {RUN, FAULT} state_t;
    state_t     state_q, state_d;
    logic [1:0] fault_code_q, fault_code_d;
    logic       halt_q, halt_d;

    assign run_ok = (state_q == RUN);
`else
    assign run_ok = 1'b1;
`endif

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = top_q + TW'(1);
`ifdef CALL_STACK_FAULT_EN
        state_d      = state_q;
        fault_code_d = fault_code_q;
`endif
        if (clear_fault) begin
            top_d   = '0;
            count_d = '0;
`ifdef CALL_STACK_FAULT_EN
            state_d      = RUN;
            fault_code_d = 2'b00;
`endif
        end else if (run_ok) begin
            // push+pop on an empty stack degenerates to a plain push
            if (push && (!pop || is_empty)) begin
                if (!is_full) begin
                    top_d   = top_q + TW'(1);
                    count_d = count_q + CW'(1);
                    wr_en   = 1'b1;
                end else begin
`ifdef CALL_STACK_FAULT_EN
                    state_d      = FAULT;
                    fault_code_d = 2'b01;
`else
                    top_d = top_q + TW'(1);
                    wr_en = 1'b1;
`endif
                end
            end else if (push && pop) begin
                wr_en  = 1'b1;
                wr_idx = top_q;
            end else if (pop) begin
                if (!is_empty) begin
                    top_d   = top_q - TW'(1);
                    count_d = count_q - CW'(1);
                end else begin
`ifdef CALL_STACK_FAULT_EN
                    state_d      = FAULT;
                    fault_code_d = 2'b10;
`endif
                end
            end
        end
`ifdef CALL_STACK_FAULT_EN
        halt_d = (state_d == FAULT);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_q   <= '0;
            count_q <= '0;
`ifdef CALL_STACK_FAULT_EN
            state_q      <= RUN;
            fault_code_q <= 2'b00;
            halt_q       <= 1'b0;
`endif
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
`ifdef CALL_STACK_FAULT_EN
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            halt_q       <= halt_d;
`endif
        end
    end

    // Storage is not reset; a write racing reset is invisible because count is zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= ret_addr_in;
        end
    end

    assign ret_addr_out = is_empty ? '0 : mem_q[top_q];
    assign count        = count_q;
    assign empty        = is_empty;
    assign full         = is_full;

`ifdef CALL_STACK_FAULT_EN
    assign halt       = halt_q;
    assign fault_code = fault_code_q;
`else
    assign halt       = 1'b0;
    assign fault_code = 2'b00;
`endif

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Scoreboard bench for call_stack_ctrl: a queue-based stack model predicts the visible state every cycle.
module tb_call_stack_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 12;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0, pop = 1'b0, clear_fault = 1'b0;
    logic [AW-1:0] ret_addr_in = '0;
    logic [AW-1:0] ret_addr_out;
    logic [CW-1:0] count;
    logic          empty, full, halt;
    logic [1:0]    fault_code;

    call_stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .ret_addr_in(ret_addr_in),
        .clear_fault(clear_fault), .ret_addr_out(ret_addr_out), .count(count),
        .empty(empty), .full(full), .halt(halt), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          emp;
        logic          ful;
        logic          hlt;
        logic [1:0]    fc;
        logic [AW-1:0] ret;
    } obs_t;

    obs_t          exp_q[$];
    int            checks = 0;
    int            failures = 0;

    // Reference model: the stack is a plain queue, newest entry at the back.
    logic [AW-1:0] stk[$];
    bit            m_fault = 0;
    logic [1:0]    m_code = 2'b00;

    function automatic obs_t model_obs();
        obs_t o;
        o.cnt = CW'(stk.size());
        o.emp = (stk.size() == 0);
        o.ful = (stk.size() == DEPTH);
        o.hlt = m_fault;
        o.fc  = m_code;
        o.ret = (stk.size() == 0) ? '0 : stk[stk.size()-1];
        return o;
    endfunction

    function automatic void model_reset();
        stk.delete();
        m_fault = 0;
        m_code  = 2'b00;
    endfunction

    function automatic void model_step(input logic p, input logic q, input logic [AW-1:0] a, input logic c);
        if (c) begin
            model_reset();
        end else if (!m_fault) begin
            if (p && q && stk.size() != 0) begin
                stk[stk.size()-1] = a;
            end else if (p) begin
                if (stk.size() < DEPTH) begin
                    stk.push_back(a);
                end else begin
`ifdef CALL_STACK_FAULT_EN
                    m_fault = 1;
                    m_code  = 2'b01;
`else
                    void'(stk.pop_front());
                    stk.push_back(a);
`endif
                end
            end else if (q) begin
                if (stk.size() != 0) begin
                    void'(stk.pop_back());
                end else begin
`ifdef CALL_STACK_FAULT_EN
                    m_fault = 1;
                    m_code  = 2'b10;
`endif
                end
            end
        end
    endfunction

    task automatic check_obs(input string nm, input obs_t e);
        obs_t a;
        a.cnt = count;
        a.emp = empty;
        a.ful = full;
        a.hlt = halt;
        a.fc  = fault_code;
        a.ret = ret_addr_out;
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s @%0t: actual cnt=%0d emp=%b full=%b halt=%b fc=%b ret=%h required cnt=%0d emp=%b full=%b halt=%b fc=%b ret=%h",
                     nm, $time, a.cnt, a.emp, a.ful, a.hlt, a.fc, a.ret, e.cnt, e.emp, e.ful, e.hlt, e.fc, e.ret);
        end
    endtask

    // One cycle of stimulus: record what must be visible before this edge, then advance the model.
    task automatic step(input logic p, input logic q, input logic [AW-1:0] a, input logic c);
        @(negedge clk);
        push        = p;
        pop         = q;
        ret_addr_in = a;
        clear_fault = c;
        exp_q.push_back(model_obs());
        model_step(p, q, a, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_obs("cycle", e);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual time=%0t required finish before 500000", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        obs_t rst_exp;
        rst_exp = '0;
        rst_exp.emp = 1'b1;
        #7;
        check_obs("reset_state", rst_exp);
        @(negedge clk);
        rst = 1'b1;

        // LIFO order with same-cycle pop data
        step(1, 0, 12'h010, 0);
        step(1, 0, 12'h020, 0);
        step(1, 0, 12'h030, 0);
        step(0, 1, '0, 0);
        step(0, 1, '0, 0);
        step(0, 1, '0, 0);
        idle(1);

        // replace via simultaneous push+pop, and push+pop on empty
        step(1, 0, 12'h100, 0);
        step(1, 1, 12'h1AB, 0);
        idle(1);
        step(0, 1, '0, 0);
        step(1, 1, 12'h055, 0);
        idle(1);
        step(0, 0, '0, 1);

        // nine pushes: overflow trap or oldest-entry overwrite
        for (int i = 1; i <= 9; i++) step(1, 0, AW'(i), 0);
        idle(2);
        for (int i = 0; i < 9; i++) step(0, 1, '0, 0);
        idle(1);
        step(0, 0, '0, 1);
        idle(1);

        // underflow, then pushes that must be ignored while trapped
        step(0, 1, '0, 0);
        step(1, 0, 12'h0AA, 0);
        step(1, 0, 12'h0BB, 0);
        idle(1);
        step(0, 0, '0, 1);
        step(1, 0, 12'h0CC, 0);
        idle(1);
        step(0, 0, '0, 1);

        // clear_fault wins over push in the same cycle
        step(1, 0, 12'h0DD, 1);
        idle(1);

        // randomized traffic with alternating push-heavy and pop-heavy phases
        for (int i = 0; i < 2000; i++) begin
            logic p, q, c;
            int   bias;
            bias = ((i / 64) % 2 == 0) ? 3 : 1;
            p = ($urandom_range(0, 3) < bias);
            q = ($urandom_range(0, 3) >= bias);
            if ($urandom_range(0, 7) == 0) q = 1'b1;
            c = ($urandom_range(0, 39) == 0);
            step(p, q, AW'($urandom), c);
        end

        // asynchronous reset between edges with count = 5 and a push pending
        step(0, 0, '0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, AW'(12'h200 + i), 0);
        idle(1);
        @(posedge clk);
        #3;
        push        = 1'b1;
        ret_addr_in = 12'h3FF;
        rst         = 1'b0;
        model_reset();
        #1;
        check_obs("async_reset", rst_exp);
        @(posedge clk);
        #1;
        check_obs("reset_push_lost", rst_exp);
        @(negedge clk);
        push = 1'b0;
        rst  = 1'b1;
        idle(2);
        step(1, 0, 12'h321, 0);
        idle(1);

        repeat (4) @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: actual pending=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
